// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t      : receiver FSM state encoding
//   FRAME_DATA_BITS : data bits per 8N1 frame
//   SYNC_START/END  : framing bytes that bracket a frequency word for the
//                     downstream assembler
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int FRAME_DATA_BITS = 8;

    localparam logic [7:0] SYNC_START = 8'hFF;
    localparam logic [7:0] SYNC_END   = 8'hFE;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals asynchronous to clk.
//   clk   : destination clock
//   rst_n : async active-low reset, flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
module sync_2ff #(
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver, LSB first.
//   clk       : system clock
//   rst_n     : async active-low reset
//   rx        : raw serial line, idle high
//   rx_data   : last correctly received byte
//   rx_valid  : one-cycle strobe, rx_data updated this cycle
//   frame_err : one-cycle strobe, stop bit sampled low
//   busy      : high while the FSM is outside IDLE
//
// state | meaning
// IDLE  | line idle, waiting for a low level
// START | timing to mid start bit to reject glitches
// DATA  | sampling 8 data bits at mid-bit
// STOP  | sampling the stop bit at mid-bit
// BREAK | stop bit was low, waiting for the line to go high again
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    // Must be at least 4 so the half-bit start check has room.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    BIT_LAST = 3'(FRAME_DATA_BITS - 1);

    rx_state_t     state;
    logic          rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        clk_cnt <= '0;
                        state   <= START;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == CNT_HALF) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            clk_cnt <= '0;
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        // Right shift: first (LSB) bit ends up in sh[0].
                        sh      <= {rx_s, sh[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch a
                    // back-to-back start edge.
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            rx_data  <= sh;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver, 8N1 frame format, LSB first. Sits directly upstream of the frequency-word assembler. Converts the raw RX pin into byte strobes on rx_data/rx_valid, which feed the assembler's data_input/rx_valid inputs. Flags framing errors and exposes a busy indicator for status or LED use.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD_RATE, 115200, line rate in bit/s.
CLKS_PER_BIT (localparam), CLK_FREQ/BAUD_RATE using integer division, clock cycles per bit. Must be at least 4.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
rx  input  1  raw serial line; idle high; asynchronous to clk.
rx_data  output  8  last correctly received byte.
rx_valid  output  1  one-cycle strobe; rx_data is new this cycle.
frame_err  output  1  one-cycle strobe; stop bit was sampled low.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): rx_data=8'h00, rx_valid=0, frame_err=0, busy=0, state=IDLE, counters=0. Both synchronizer flops reset to 1 (line idle).
- rx passes through a 2-FF synchronizer. rx_s is the second flop's output. All decisions use rx_s only.
- bit_cnt is 3 bits. clk_cnt is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
- State machine:
  - IDLE: when rx_s==0, clear clk_cnt and go to START.
  - START: at clk_cnt==CLKS_PER_BIT/2-1 (mid start bit), re-sample rx_s.
    - rx_s==1: false start; go to IDLE with no strobe.
    - rx_s==0: clear clk_cnt and bit_cnt, go to DATA.
  - DATA: at each clk_cnt==CLKS_PER_BIT-1, shift rx_s into the MSB of shift register sh (right shift, so LSB-first order is restored). Increment bit_cnt. After the 8th sample go to STOP.
  - STOP: at clk_cnt==CLKS_PER_BIT-1 (mid stop bit), sample rx_s.
    - rx_s==1: rx_data<=sh; rx_valid=1 for exactly that following cycle; go to IDLE.
    - rx_s==0: frame_err=1 for one cycle; rx_data is unchanged; go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. Prevents a held-low line or break from retriggering continuously.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with no idle gap. The next start edge is detected within the remaining half bit.
- Latency: the rx_valid rising edge occurs 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start-bit falling edge on rx, with ±1 cycle for sampling phase.
- rx_valid and frame_err are never high in the same cycle. Neither ever lasts more than one cycle.
- No input buffering. The downstream block must accept a strobe in any cycle.
- Reset asserted mid-frame aborts the frame immediately with no strobe. After release, the FSM starts in IDLE. A line still low after release is treated as a new start bit.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum: IDLE, START, DATA, STOP, BREAK (3 bits);
  - FRAME_DATA_BITS=8;
  - the sync byte constants 8'hFF (frame start) and 8'hFE (frame end), used by the downstream assembler and by benches.
- One natural sub-module, sync_2ff: a parameterisable-width 2-flop synchronizer with a reset value parameter. Instantiated here with width 1, reset value 1.

Test Plan (CLK_FREQ=1000000, BAUD_RATE=100000, so CLKS_PER_BIT=10):
1. Single byte 8'hA5, ideal timing -> exactly one rx_valid pulse, rx_data=8'hA5, frame_err never high. Pulse occurs at 2+5+90 cycles after the falling edge, ±1.
2. Back-to-back frames 8'hFF, 8'h12, 8'h34, 8'hFE with zero idle bits -> four rx_valid pulses in order with matching rx_data. Downstream assembler output becomes 28'h0001234.
3. Glitch: rx low for 3 cycles, then high -> START aborts, no rx_valid or frame_err, busy returns to 0.
4. Frame 8'h3C with stop bit low, line held low 50 cycles, then high, then frame 8'h55 -> one frame_err pulse and rx_data remains unchanged. Exactly one frame_err (no retriggering during the low hold). Then rx_valid with rx_data=8'h55.
5. rst_n asserted during bit 4 of 8'hC3 -> all outputs go to reset values asynchronously with no strobe. A subsequent 8'h81 is received correctly.
6. Bit period stretched to 10.4 and shrunk to 9.6 clocks (±4%) for 8'h96 -> received correctly in both cases with no frame_err.
